// File: rtl/pool_pkg.sv
// Shared constants, types and the signed-max helper for the 2x2 max-pool + ReLU stage.
package pool_pkg;

    localparam int CH         = 32;
    localparam int DW         = 32;
    localparam int OUT_W      = 13;
    localparam int OUT_H      = 17;
    localparam int FIFO_DEPTH = 4;

    typedef logic signed [DW-1:0] word_t;

    typedef struct packed {
        logic [4:0] row;
        logic [3:0] col;
        logic       last;
    } coord_t;

    function automatic word_t smax(input word_t a, input word_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO; the head word is read straight from storage.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop_eff;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    // A pop against an empty FIFO is dropped rather than corrupting the pointers.
    assign pop_eff = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i)  wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_eff) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_i, pop_eff})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst_n) !(push_i && full_o));

endmodule

// File: rtl/pool_relu_stage.sv
// 2x2 signed max-pool followed by ReLU over 32 channels, raster-tagged, with a
// credit-gated output FIFO so in-flight windows always have a slot waiting.
module pool_relu_stage
    import pool_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 win_valid,
    output logic                 win_ready,
    input  logic [CH*4*DW-1:0]   win_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DW-1:0]     out_data,
    output logic [4:0]           out_row,
    output logic [3:0]           out_col,
    output logic                 out_last,
    output logic                 frame_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int FW    = CH*DW + $bits(coord_t);

    logic             accept;
    logic             pop;
    logic [4:0]       row_q, row_d;
    logic [3:0]       col_q, col_d;
    coord_t           tag;
    logic             s1_valid_q;
    coord_t           s1_coord_q;
    logic             s2_valid_q;
    coord_t           s2_coord_q;
    logic [CH*DW-1:0] s2_data_q;
    logic [CH*DW-1:0] s2_data_d;
    logic             frame_done_q;
    logic [FW-1:0]    fifo_din;
    logic [FW-1:0]    fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W:0]   credits_used;
    coord_t           head_coord;

    // Every window in S1/S2 already owns a FIFO slot, so the FIFO cannot overflow.
    assign credits_used = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(s1_valid_q) + (CNT_W+1)'(s2_valid_q);
    assign win_ready    = credits_used < (CNT_W+1)'(FIFO_DEPTH);
    assign accept       = win_valid & win_ready;
    assign pop          = out_valid & out_ready;

    always_comb begin
        tag.row  = row_q;
        tag.col  = col_q;
        tag.last = (row_q == 5'(OUT_H-1)) && (col_q == 4'(OUT_W-1));
        row_d    = row_q;
        col_d    = col_q;
        if (accept) begin
            if (col_q == 4'(OUT_W-1)) begin
                col_d = '0;
                row_d = tag.last ? '0 : row_q + 5'd1;
            end else begin
                col_d = col_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            row_q        <= '0;
            col_q        <= '0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            s1_valid_q   <= accept;
            s2_valid_q   <= s1_valid_q;
            frame_done_q <= pop & out_last;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)     s1_coord_q <= tag;
        if (s1_valid_q) begin
            s2_coord_q <= s1_coord_q;
            s2_data_q  <= s2_data_d;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        word_t e0, e1, e2, e3;
        word_t m0_q, m1_q;
        word_t pooled;

        assign e0 = win_data[c*4*DW + 0*DW +: DW];
        assign e1 = win_data[c*4*DW + 1*DW +: DW];
        assign e2 = win_data[c*4*DW + 2*DW +: DW];
        assign e3 = win_data[c*4*DW + 3*DW +: DW];

        always_ff @(posedge clk) begin
            if (accept) begin
                m0_q <= smax(e0, e1);
                m1_q <= smax(e2, e3);
            end
        end

        assign pooled                  = smax(m0_q, m1_q);
        assign s2_data_d[c*DW +: DW]   = pooled[DW-1] ? '0 : pooled;
    end

    assign fifo_din = {s2_coord_q, s2_data_q};

    sync_fifo_fwft #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (s2_valid_q),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_coord = fifo_dout[FW-1 -: $bits(coord_t)];
    assign out_valid  = ~fifo_empty;
    assign out_data   = fifo_dout[CH*DW-1:0];
    assign out_row    = head_coord.row;
    assign out_col    = head_coord.col;
    assign out_last   = head_coord.last;
    assign frame_done = frame_done_q;

    a_credit_holds: assert property (@(posedge clk) disable iff (rst_n) !(s2_valid_q && fifo_full));

endmodule

// File: tb/tb_pool_relu_stage.sv
// Directed bench for pool_relu_stage: a queue-based reference of accepted windows
// is checked every cycle, plus literal expectations for the hand-worked cases.
module tb_pool_relu_stage;

    localparam int CH    = 32;
    localparam int DW    = 32;
    localparam int OUT_W = 13;
    localparam int OUT_H = 17;
    localparam int DEPTH = 4;
    localparam int NPIX  = OUT_W * OUT_H;
    localparam int WW    = CH*4*DW;
    localparam int OW    = CH*DW;
    localparam int EW    = OW + 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          win_valid;
    logic          win_ready;
    logic [WW-1:0] win_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [4:0]    out_row;
    logic [3:0]    out_col;
    logic          out_last;
    logic          frame_done;

    always #5 clk = ~clk;

    pool_relu_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 0;

    logic [EW-1:0] exp_q[$];
    int            vis_q[$];
    int            idx_m    = 0;
    bit            fd_exp   = 0;
    int            acc_cnt  = 0;
    int            pop_cnt  = 0;
    int            fd_cnt   = 0;
    int            last_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_data(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            int bad;
            bad = 0;
            for (int c = CH-1; c >= 0; c--)
                if (act[c*DW +: DW] !== exp[c*DW +: DW]) bad = c;
            failures++;
            $display("FAIL %s ch%0d actual=%h required=%h (cycle %0d)", name, bad,
                     act[bad*DW +: DW], exp[bad*DW +: DW], cyc);
        end
    endtask

    // Reference: signed max of the four elements, clamp negatives, raster coordinates.
    function automatic logic [EW-1:0] model_px(input logic [WW-1:0] w, input int idx);
        logic [OW-1:0] d;
        int r, c;
        for (int ch = 0; ch < CH; ch++) begin
            logic signed [DW-1:0] m, e;
            m = w[ch*4*DW +: DW];
            for (int k = 1; k < 4; k++) begin
                e = w[ch*4*DW + k*DW +: DW];
                if (e > m) m = e;
            end
            if (m < 0) m = 0;
            d[ch*DW +: DW] = m;
        end
        r = idx / OUT_W;
        c = idx % OUT_W;
        return {5'(r), 4'(c), (idx == NPIX-1), d};
    endfunction

    function automatic logic [WW-1:0] win_all(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c, input logic [31:0] d);
        logic [WW-1:0] w;
        for (int ch = 0; ch < CH; ch++)
            w[ch*4*DW +: 4*DW] = {d, c, b, a};
        return w;
    endfunction

    function automatic logic [WW-1:0] pat(input int seed);
        logic [WW-1:0] w;
        for (int ch = 0; ch < CH; ch++)
            for (int k = 0; k < 4; k++)
                w[ch*4*DW + k*DW +: DW] = 32'(((seed + ch*3 + k*7) % 11) * 13 - 60);
        return w;
    endfunction

    always @(negedge clk) begin : mon
        logic [EW-1:0] head;
        bit            exp_ov;
        if (mon_en) begin
            chk("frame_done", frame_done, fd_exp);
            exp_ov = (exp_q.size() > 0) && (vis_q[0] <= cyc);
            chk("out_valid", out_valid, exp_ov);
            chk("win_ready", win_ready, exp_q.size() < DEPTH);
            if (frame_done) fd_cnt++;
            fd_exp = 0;
            if (out_valid && out_ready && !rst_n) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 1, 0);
                end else begin
                    head = exp_q.pop_front();
                    void'(vis_q.pop_front());
                    chk_data("pop_data", out_data, head[OW-1:0]);
                    chk("pop_row", out_row, head[OW+9:OW+5]);
                    chk("pop_col", out_col, head[OW+4:OW+1]);
                    chk("pop_last", out_last, head[OW]);
                    fd_exp = head[OW];
                    pop_cnt++;
                    if (out_last) last_cnt++;
                end
            end
            if (win_valid && win_ready && !rst_n) begin
                exp_q.push_back(model_px(win_data, idx_m));
                vis_q.push_back(cyc + 3);
                idx_m = (idx_m + 1) % NPIX;
                acc_cnt++;
            end
            if (rst_n) begin
                exp_q.delete();
                vis_q.delete();
                idx_m  = 0;
                fd_exp = 0;
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        align();
        rst_n = 1'b0;
    endtask

    task automatic send(input logic [WW-1:0] w);
        bit done;
        done      = 0;
        win_data  = w;
        win_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (win_ready) done = 1;
            align();
        end
        win_valid = 1'b0;
        chk("send_timeout", done, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) align();
        chk("drain_empty", exp_q.size(), 0);
        repeat (3) align();
    endtask

    task automatic wait_head(input string name);
        bit ok;
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = out_valid;
        end
        chk(name, ok, 1);
    endtask

    task automatic corner(input string name, input logic [WW-1:0] w, input logic [31:0] exp);
        drain();
        send(w);
        wait_head(name);
        chk(name, out_data[31:0], exp);
        chk(name, out_data[OW-1 -: DW], exp);
        align();
    endtask

    initial begin : watchdog
        #300000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stim
        logic [WW-1:0] w;
        int t0, a0, p0;

        win_valid = 1'b0;
        win_data  = '0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b0;
        mon_en = 1;

        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_win_ready", win_ready, 1);
        align();

        // Single window: ch0 {5,-3,9,2} -> 9, others {-1,-2,-3,-4} -> 0.
        w = win_all(32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC);
        w[127:0] = {32'd2, 32'd9, 32'hFFFFFFFD, 32'd5};
        send(w);
        @(negedge clk);
        chk("lat_edge1", out_valid, 0);
        @(negedge clk);
        chk("lat_edge2", out_valid, 0);
        @(negedge clk);
        chk("lat_visible", out_valid, 1);
        chk("t1_ch0", out_data[31:0], 32'd9);
        chk("t1_ch1", out_data[63:32], 32'd0);
        chk("t1_ch31", out_data[OW-1 -: DW], 32'd0);
        chk("t1_row", out_row, 0);
        chk("t1_col", out_col, 0);
        chk("t1_last", out_last, 0);
        align();
        drain();

        // Full frame back to back, then first pixel of the next frame.
        do_reset();
        fd_cnt   = 0;
        last_cnt = 0;
        p0       = pop_cnt;
        t0       = cyc;
        for (int i = 0; i < NPIX; i++) send(pat(i));
        chk("frame_accept_cycles", cyc - t0, NPIX);
        drain();
        chk("frame_pops", pop_cnt - p0, NPIX);
        chk("frame_done_pulses", fd_cnt, 1);
        chk("frame_last_count", last_cnt, 1);
        send(pat(5));
        wait_head("f2_head");
        chk("f2_row", out_row, 0);
        chk("f2_col", out_col, 0);
        chk("f2_last", out_last, 0);
        align();
        drain();

        // Backpressure: only FIFO_DEPTH windows may be admitted.
        out_ready = 1'b0;
        a0        = acc_cnt;
        win_data  = pat(1000);
        win_valid = 1'b1;
        repeat (8) begin
            align();
            win_data = pat(1000 + acc_cnt - a0);
        end
        chk("bp_accepts", acc_cnt - a0, 4);
        @(negedge clk);
        chk("bp_win_ready_low", win_ready, 0);
        align();
        win_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_win_ready_back", win_ready, 1);
        align();
        drain();

        corner("c_most_neg", win_all(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000), 32'd0);
        corner("c_most_pos", win_all(32'h7FFFFFFF, 32'd0, 32'd0, 32'd0), 32'h7FFFFFFF);
        corner("c_neg_eq", win_all(32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9), 32'd0);
        corner("c_pos_eq", win_all(32'd4, 32'd4, 32'd4, 32'd4), 32'd4);
        drain();

        // Preload three pixels, then stream while popping.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(pat(300 + i));
        repeat (3) align();
        @(negedge clk);
        chk("cnt3_win_ready", win_ready, 1);
        align();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(pat(400 + i));
        drain();

        // Reset mid-stream with windows in flight.
        do_reset();
        for (int i = 0; i < 50; i++) send(pat(600 + i));
        rst_n = 1'b1;
        align();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_win_ready", win_ready, 1);
        repeat (5) align();
        send(pat(7));
        wait_head("mid_rst_head");
        chk("mid_rst_row", out_row, 0);
        chk("mid_rst_col", out_col, 0);
        align();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
